// File: rtl/cpu_out_uart_tx_if.sv
// Store-output port between the CPU (master) and the UART consumer (slave).
interface cpu_out_uart_tx_if #(
  parameter int unsigned FIFO_DEPTH = 8
);

  logic                          write_i;
  logic [31:0]                   value_i;
  logic                          tx_o;
  logic                          busy_o;
  logic                          full_o;
  logic                          overflow_o;
  logic [$clog2(FIFO_DEPTH):0]   level_o;

  // Producer side: drives store strobes, observes line and FIFO status.
  modport master (
    output write_i,
    output value_i,
    input  tx_o,
    input  busy_o,
    input  full_o,
    input  overflow_o,
    input  level_o
  );

  // Consumer side: the FIFO + UART transmitter.
  modport slave (
    input  write_i,
    input  value_i,
    output tx_o,
    output busy_o,
    output full_o,
    output overflow_o,
    output level_o
  );

endinterface

// File: rtl/cpu_out_uart_tx.sv
// CPU store-output consumer: byte FIFO drained by a UART 8N1 transmitter.
// The producer has no backpressure; writes into a full FIFO are dropped and
// latch a sticky overflow flag.
module cpu_out_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  cpu_out_uart_tx_if.slave        bus_io
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = PW + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BaudLast  = BW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;

  // Transmitter state
  state_e        r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_busy;

  // Next-state and control wires
  state_e        w_state_nxt;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_tx_nxt;
  logic          w_busy_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_full;
  logic          w_nonempty;
  logic          w_baud_last;
  logic [LW-1:0] w_level_nxt;
  logic [7:0]    w_head;

  // Only the low byte of a store is transmitted.
  logic          w_unused_value;
  assign w_unused_value = ^bus_io.value_i[31:8];

  assign w_full      = (r_level == LevelFull);
  assign w_nonempty  = (r_level != '0);
  assign w_push      = bus_io.write_i & ~w_full;
  assign w_drop      = bus_io.write_i & w_full;
  assign w_baud_last = (r_baud == BaudLast);
  assign w_head      = r_mem[r_rptr];
  // Pop is only ever issued with a non-empty FIFO, so this cannot underflow;
  // a full FIFO never pushes, so a same-edge pop cannot rescue a dropped byte.
  assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

  // FIFO storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus_io.value_i[7:0];
    end
  end

  // FIFO pointers, level and sticky overflow flag.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_level <= w_level_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // FSM state register together with its datapath and registered outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next-state logic: bit timing, shifter and FIFO pop decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      StIdle: begin
        w_baud_nxt = '0;
        if (w_nonempty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = StStart;
        end
      end
      StStart: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = StData;
        end
      end
      StData: begin
        if (w_baud_last) begin
          w_baud_nxt  = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = StStop;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      StStop: begin
        if (w_baud_last) begin
          w_baud_nxt = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (w_nonempty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = StStart;
          end else begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: begin
        w_baud_nxt  = '0;
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Output decode from the upcoming state so tx/busy come straight from flops.
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = (w_state_nxt != StIdle);
    case (w_state_nxt)
      StStart: w_tx_nxt = 1'b0;
      StData:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign bus_io.tx_o       = r_tx;
  assign bus_io.busy_o     = r_busy;
  assign bus_io.full_o     = w_full;
  assign bus_io.overflow_o = r_overflow;
  assign bus_io.level_o    = r_level;

endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// Directed bench for cpu_out_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=8).
module tb_cpu_out_uart_tx;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Depth = 8;

  logic clk_i;
  logic rstn_i;

  int checks;
  int errors;
  int busy_cnt;
  int max_lvl;

  cpu_out_uart_tx_if #(.FIFO_DEPTH(Depth)) u_if ();

  cpu_out_uart_tx #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth)
  ) u_dut (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .bus_io(u_if)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called one step after the edge that loaded the frame; checks tx for all
  // 10*Cpb cycles and returns one step after the edge following the stop bit.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic exp_bit;
    for (int c = 0; c < 10 * Cpb; c++) begin
      if (c < Cpb) exp_bit = 1'b0;
      else if (c < 9 * Cpb) exp_bit = b[(c - Cpb) / Cpb];
      else exp_bit = 1'b1;
      chk($sformatf("%s tx c%0d", tag, c), 32'(u_if.tx_o), 32'(exp_bit));
      if (u_if.busy_o === 1'b1) busy_cnt++;
      if (int'(u_if.level_o) > max_lvl) max_lvl = int'(u_if.level_o);
      tick();
    end
  endtask

  // One isolated write into an idle, empty transmitter.
  task automatic single_frame(input string tag, input logic [31:0] val, input logic [7:0] b);
    u_if.value_i = val;
    u_if.write_i = 1'b1;
    tick();
    u_if.write_i = 1'b0;
    chk({tag, " level after push"}, 32'(u_if.level_o), 32'd1);
    chk({tag, " busy before pop"}, 32'(u_if.busy_o), 32'd0);
    chk({tag, " tx before pop"}, 32'(u_if.tx_o), 32'd1);
    tick();
    chk({tag, " busy after pop"}, 32'(u_if.busy_o), 32'd1);
    chk({tag, " level after pop"}, 32'(u_if.level_o), 32'd0);
    busy_cnt = 0;
    check_frame(tag, b);
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'd40);
    chk({tag, " busy after frame"}, 32'(u_if.busy_o), 32'd0);
    chk({tag, " tx after frame"}, 32'(u_if.tx_o), 32'd1);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    busy_cnt     = 0;
    max_lvl      = 0;
    rstn_i       = 1'b0;
    u_if.write_i = 1'b0;
    u_if.value_i = '0;
    tick();
    tick();

    // Reset values
    chk("rst tx", 32'(u_if.tx_o), 32'd1);
    chk("rst busy", 32'(u_if.busy_o), 32'd0);
    chk("rst full", 32'(u_if.full_o), 32'd0);
    chk("rst overflow", 32'(u_if.overflow_o), 32'd0);
    chk("rst level", 32'(u_if.level_o), 32'd0);
    rstn_i = 1'b1;
    tick();

    // Single byte, then upper value bits ignored
    single_frame("t1", 32'h0000_0041, 8'h41);
    single_frame("t2", 32'hDEAD_BE55, 8'h55);

    // Three writes 4 cycles apart: back-to-back frames
    busy_cnt = 0;
    max_lvl  = 0;
    fork
      begin
        u_if.value_i = 32'h11; u_if.write_i = 1'b1; tick(); u_if.write_i = 1'b0;
        repeat (3) tick();
        u_if.value_i = 32'h22; u_if.write_i = 1'b1; tick(); u_if.write_i = 1'b0;
        repeat (3) tick();
        u_if.value_i = 32'h33; u_if.write_i = 1'b1; tick(); u_if.write_i = 1'b0;
      end
      begin
        tick();
        tick();
        check_frame("t3 f0", 8'h11);
        check_frame("t3 f1", 8'h22);
        check_frame("t3 f2", 8'h33);
      end
    join
    chk("t3 busy cycles", 32'(busy_cnt), 32'd120);
    chk("t3 peak level", 32'(max_lvl), 32'd2);
    chk("t3 busy after", 32'(u_if.busy_o), 32'd0);

    // Ten consecutive writes: byte 9 dropped
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          u_if.value_i = 32'(i);
          u_if.write_i = 1'b1;
          tick();
          if (i == 8) begin
            chk("t4 full after edge 8", 32'(u_if.full_o), 32'd1);
            chk("t4 level after edge 8", 32'(u_if.level_o), 32'd8);
            chk("t4 overflow after edge 8", 32'(u_if.overflow_o), 32'd0);
          end
          if (i == 9) begin
            chk("t4 overflow after edge 9", 32'(u_if.overflow_o), 32'd1);
            chk("t4 full after edge 9", 32'(u_if.full_o), 32'd1);
          end
        end
        u_if.write_i = 1'b0;
      end
      begin
        tick();
        tick();
        for (int k = 0; k < 9; k++) begin
          check_frame($sformatf("t4 f%0d", k), 8'(k));
        end
      end
    join
    chk("t4 level end", 32'(u_if.level_o), 32'd0);
    chk("t4 full end", 32'(u_if.full_o), 32'd0);
    chk("t4 overflow sticky", 32'(u_if.overflow_o), 32'd1);
    chk("t4 busy end", 32'(u_if.busy_o), 32'd0);

    // Asynchronous reset in the middle of data bit 3, with a byte queued
    u_if.value_i = 32'hA5; u_if.write_i = 1'b1; tick(); u_if.write_i = 1'b0;
    tick();
    u_if.value_i = 32'h77; u_if.write_i = 1'b1; tick(); u_if.write_i = 1'b0;
    repeat (16) tick();
    chk("t5 tx bit3 before rst", 32'(u_if.tx_o), 32'd0);
    chk("t5 busy before rst", 32'(u_if.busy_o), 32'd1);
    chk("t5 level before rst", 32'(u_if.level_o), 32'd1);
    #2 rstn_i = 1'b0;
    #1;
    chk("t5 tx in rst", 32'(u_if.tx_o), 32'd1);
    chk("t5 busy in rst", 32'(u_if.busy_o), 32'd0);
    chk("t5 level in rst", 32'(u_if.level_o), 32'd0);
    chk("t5 overflow in rst", 32'(u_if.overflow_o), 32'd0);
    #1 rstn_i = 1'b1;
    tick();
    single_frame("t5 post", 32'h0000_00A5, 8'hA5);
    tick();
    chk("t5 no stale byte", 32'(u_if.busy_o), 32'd0);

    // 20 writes, one per frame time: pointers wrap twice
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          u_if.value_i = {24'hC0FFEE, 8'(k * 37 + 11)};
          u_if.write_i = 1'b1;
          tick();
          u_if.write_i = 1'b0;
          repeat (39) tick();
        end
      end
      begin
        tick();
        tick();
        for (int k = 0; k < 20; k++) begin
          check_frame($sformatf("t6 f%0d", k), 8'(k * 37 + 11));
        end
      end
    join
    chk("t6 overflow", 32'(u_if.overflow_o), 32'd0);
    chk("t6 level end", 32'(u_if.level_o), 32'd0);
    chk("t6 busy end", 32'(u_if.busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
